// File: rtl/minmax_pkg.sv
// Shared types and default widths for the min/max block scanner.
package minmax_pkg;

  localparam int MM_N  = 32;
  localparam int MM_CW = 16;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    CMP_MIN,
    CMP_MAX,
    DONE
  } state_t;

endpackage

// File: rtl/minmax_scanner_if.sv
// Handshake and result bundle of minmax_scanner; index signals exist only
// when MINMAX_INDEX_EN is defined.
interface minmax_scanner_if;
  import minmax_pkg::*;

  logic                    start;
  logic [MM_CW-1:0]        count;
  logic signed [MM_N-1:0]  in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic                    busy;
  logic                    done;
  logic signed [MM_N-1:0]  min_val;
  logic signed [MM_N-1:0]  max_val;
`ifdef MINMAX_INDEX_EN
  logic [MM_CW-1:0]        min_idx;
  logic [MM_CW-1:0]        max_idx;
`endif

`ifdef MINMAX_INDEX_EN
  modport master (output start, count, in_data, in_valid,
                  input  in_ready, busy, done, min_val, max_val, min_idx, max_idx);
  modport slave  (input  start, count, in_data, in_valid,
                  output in_ready, busy, done, min_val, max_val, min_idx, max_idx);
`else
  modport master (output start, count, in_data, in_valid,
                  input  in_ready, busy, done, min_val, max_val);
  modport slave  (input  start, count, in_data, in_valid,
                  output in_ready, busy, done, min_val, max_val);
`endif

endinterface

// File: rtl/minmax_scanner_slt.sv
// Signed less-than: lt = (a < b) treating both operands as two's complement.
module slt #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lt
);

  // Sign-extending by one bit makes the difference immune to overflow.
  logic [N:0] diff;

  assign diff = {a[N-1], a} - {b[N-1], b};
  assign lt   = diff[N];

endmodule

// File: rtl/minmax_scanner.sv
// Streams a block of signed words and reports its min/max using one shared
// comparator (two compare phases per element). MINMAX_INDEX_EN adds indices.
module minmax_scanner
  import minmax_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  minmax_scanner_if.slave   bus
);

  localparam logic [MM_CW-1:0] CNT_ONE = MM_CW'(1);

  state_t                  state_reg, state_next;
  logic [MM_CW-1:0]        remaining_reg, remaining_next;
  logic                    first_reg, first_next;
  logic signed [MM_N-1:0]  sample_reg, sample_next;
  logic signed [MM_N-1:0]  min_reg, min_next;
  logic signed [MM_N-1:0]  max_reg, max_next;
`ifdef MINMAX_INDEX_EN
  logic [MM_CW-1:0]        idx_reg, idx_next;
  logic [MM_CW-1:0]        min_idx_reg, min_idx_next;
  logic [MM_CW-1:0]        max_idx_reg, max_idx_next;
`endif

  logic [MM_N-1:0] cmp_a, cmp_b;
  logic            cmp_lt;

  // CMP_MAX asks "max < sample"; every other state asks "sample < min".
  assign cmp_a = (state_reg == CMP_MAX) ? max_reg    : sample_reg;
  assign cmp_b = (state_reg == CMP_MAX) ? sample_reg : min_reg;

  slt #(.N(MM_N)) u_slt (.a(cmp_a), .b(cmp_b), .lt(cmp_lt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      first_reg     <= 1'b0;
      sample_reg    <= '0;
      min_reg       <= '0;
      max_reg       <= '0;
`ifdef MINMAX_INDEX_EN
      idx_reg       <= '0;
      min_idx_reg   <= '0;
      max_idx_reg   <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      first_reg     <= first_next;
      sample_reg    <= sample_next;
      min_reg       <= min_next;
      max_reg       <= max_next;
`ifdef MINMAX_INDEX_EN
      idx_reg       <= idx_next;
      min_idx_reg   <= min_idx_next;
      max_idx_reg   <= max_idx_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    first_next     = first_reg;
    sample_next    = sample_reg;
    min_next       = min_reg;
    max_next       = max_reg;
`ifdef MINMAX_INDEX_EN
    idx_next       = idx_reg;
    min_idx_next   = min_idx_reg;
    max_idx_next   = max_idx_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          min_next = '0;
          max_next = '0;
`ifdef MINMAX_INDEX_EN
          idx_next     = '0;
          min_idx_next = '0;
          max_idx_next = '0;
`endif
          if (bus.count != '0) begin
            remaining_next = bus.count;
            first_next     = 1'b1;
            state_next     = ACCEPT;
          end else begin
            state_next = DONE;
          end
        end
      end
      ACCEPT: begin
        if (bus.in_valid) begin
          sample_next = bus.in_data;
          if (first_reg) begin
            // The first element seeds both extrema without a compare pass.
            min_next       = bus.in_data;
            max_next       = bus.in_data;
            first_next     = 1'b0;
            remaining_next = remaining_reg - CNT_ONE;
`ifdef MINMAX_INDEX_EN
            min_idx_next = '0;
            max_idx_next = '0;
            idx_next     = idx_reg + CNT_ONE;
`endif
            state_next = (remaining_reg == CNT_ONE) ? DONE : ACCEPT;
          end else begin
            state_next = CMP_MIN;
          end
        end
      end
      CMP_MIN: begin
        if (cmp_lt) begin
          min_next = sample_reg;
`ifdef MINMAX_INDEX_EN
          min_idx_next = idx_reg;
`endif
        end
        state_next = CMP_MAX;
      end
      CMP_MAX: begin
        if (cmp_lt) begin
          max_next = sample_reg;
`ifdef MINMAX_INDEX_EN
          max_idx_next = idx_reg;
`endif
        end
        remaining_next = remaining_reg - CNT_ONE;
`ifdef MINMAX_INDEX_EN
        idx_next = idx_reg + CNT_ONE;
`endif
        state_next = (remaining_reg == CNT_ONE) ? DONE : ACCEPT;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready = (state_reg == ACCEPT);
  assign bus.busy     = (state_reg != IDLE);
  assign bus.done     = (state_reg == DONE);
  assign bus.min_val  = min_reg;
  assign bus.max_val  = max_reg;
`ifdef MINMAX_INDEX_EN
  assign bus.min_idx  = min_idx_reg;
  assign bus.max_idx  = max_idx_reg;
`endif

endmodule

// File: tb/tb_minmax_scanner.sv
// Directed bench for minmax_scanner: latency, extrema, ties, stalls, resets.
module tb_minmax_scanner;
  import minmax_pkg::*;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  logic signed [31:0] vec [8];

  minmax_scanner_if m();

  minmax_scanner dut (.clk(clk), .rst(rst), .bus(m));

  always #5 clk = ~clk;

  // Runs one scan starting in the current cycle; data comes from vec.
  // A stall holds in_valid low for stall_len ACCEPT cycles once element
  // stall_at is due. done_cyc is cycles from start to done, -1 on timeout.
  task automatic run_scan(input int cnt, input int stall_at, input int stall_len,
                          output int done_cyc, output bit saw_ready);
    int k;
    int stall_ctr;
    int cyc;
    bit hs;
    k = 0;
    stall_ctr = 0;
    saw_ready = 1'b0;
    done_cyc = -1;
    m.start = 1'b1;
    m.count = MM_CW'(cnt);
    m.in_valid = 1'b0;
    @(posedge clk); #1;
    m.start = 1'b0;
    cyc = 1;
    while (cyc < 200) begin
      if (m.in_ready) saw_ready = 1'b1;
      if (m.done) begin
        done_cyc = cyc;
        break;
      end
      if (k == stall_at && stall_ctr < stall_len) begin
        m.in_valid = 1'b0;
        if (m.in_ready) stall_ctr++;
      end else begin
        m.in_valid = (k < cnt);
        m.in_data  = vec[k % 8];
      end
      hs = m.in_valid && m.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) k++;
    end
    m.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({m.in_ready, m.busy, m.done} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags got=%b want=000", {m.in_ready, m.busy, m.done});
    end
    tests_run++;
    if (m.min_val !== 32'sd0 || m.max_val !== 32'sd0) begin
      tests_failed++;
      $display("FAIL reset_vals got min=%0d max=%0d want 0/0", m.min_val, m.max_val);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("[TB] reset: in_ready=%b busy=%b done=%b", m.in_ready, m.busy, m.done);
  endtask

  task automatic test_basic();
    int d; bit r;
    vec[0] = 5; vec[1] = -3; vec[2] = 7; vec[3] = -3;
    run_scan(4, -1, 0, d, r);
    $display("[TB] basic: done@%0d min=%0d max=%0d", d, m.min_val, m.max_val);
    tests_run++;
    if (d !== 11) begin tests_failed++; $display("FAIL basic_latency got=%0d want=11", d); end
    tests_run++;
    if (m.min_val !== -32'sd3) begin tests_failed++; $display("FAIL basic_min got=%0d want=-3", m.min_val); end
    tests_run++;
    if (m.max_val !== 32'sd7) begin tests_failed++; $display("FAIL basic_max got=%0d want=7", m.max_val); end
`ifdef MINMAX_INDEX_EN
    tests_run++;
    if (m.min_idx !== 16'd1 || m.max_idx !== 16'd2) begin
      tests_failed++;
      $display("FAIL basic_idx got min_idx=%0d max_idx=%0d want 1/2", m.min_idx, m.max_idx);
    end
`endif
    tests_run++;
    if (m.done !== 1'b0 || m.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL done_pulse got done=%b busy=%b want 0/0", m.done, m.busy);
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (m.min_val !== -32'sd3 || m.max_val !== 32'sd7) begin
      tests_failed++;
      $display("FAIL hold got min=%0d max=%0d want -3/7", m.min_val, m.max_val);
    end
  endtask

  task automatic test_overflow();
    int d; bit r;
    vec[0] = 32'sh7FFFFFFF; vec[1] = 32'sh80000000;
    run_scan(2, -1, 0, d, r);
    $display("[TB] overflow: done@%0d min=%h max=%h", d, m.min_val, m.max_val);
    tests_run++;
    if (d !== 5) begin tests_failed++; $display("FAIL ovf_latency got=%0d want=5", d); end
    tests_run++;
    if (m.min_val !== 32'sh80000000 || m.max_val !== 32'sh7FFFFFFF) begin
      tests_failed++;
      $display("FAIL ovf_vals got min=%h max=%h want 80000000/7fffffff", m.min_val, m.max_val);
    end
  endtask

  task automatic test_zero_count();
    int d; bit r;
    run_scan(0, -1, 0, d, r);
    $display("[TB] zero: done@%0d ready_seen=%b min=%0d max=%0d", d, r, m.min_val, m.max_val);
    tests_run++;
    if (d !== 1) begin tests_failed++; $display("FAIL zero_latency got=%0d want=1", d); end
    tests_run++;
    if (r !== 1'b0) begin tests_failed++; $display("FAIL zero_ready got=%b want=0", r); end
    tests_run++;
    if (m.min_val !== 32'sd0 || m.max_val !== 32'sd0) begin
      tests_failed++;
      $display("FAIL zero_clear got min=%0d max=%0d want 0/0", m.min_val, m.max_val);
    end
  endtask

  task automatic test_stall();
    int d0, d1; bit r;
    logic signed [31:0] mn0, mx0;
    vec[0] = 4; vec[1] = -9; vec[2] = 12;
    run_scan(3, -1, 0, d0, r);
    mn0 = m.min_val; mx0 = m.max_val;
    run_scan(3, 1, 5, d1, r);
    $display("[TB] stall: done@%0d vs %0d min=%0d max=%0d", d1, d0, m.min_val, m.max_val);
    tests_run++;
    if (d0 !== 8) begin tests_failed++; $display("FAIL nostall_latency got=%0d want=8", d0); end
    tests_run++;
    if (d1 !== 13) begin tests_failed++; $display("FAIL stall_latency got=%0d want=13", d1); end
    tests_run++;
    if (m.min_val !== -32'sd9 || m.max_val !== 32'sd12 || mn0 !== -32'sd9 || mx0 !== 32'sd12) begin
      tests_failed++;
      $display("FAIL stall_vals got min=%0d max=%0d (nostall %0d/%0d) want -9/12",
               m.min_val, m.max_val, mn0, mx0);
    end
  endtask

  task automatic test_single();
    int d; bit r;
    vec[0] = -42;
    run_scan(1, -1, 0, d, r);
    $display("[TB] single: done@%0d min=%0d max=%0d", d, m.min_val, m.max_val);
    tests_run++;
    if (d !== 2) begin tests_failed++; $display("FAIL single_latency got=%0d want=2", d); end
    tests_run++;
    if (m.min_val !== -32'sd42 || m.max_val !== -32'sd42) begin
      tests_failed++;
      $display("FAIL single_vals got min=%0d max=%0d want -42/-42", m.min_val, m.max_val);
    end
  endtask

  task automatic test_reset_mid_scan();
    int d; bit r;
    m.start = 1'b1; m.count = 16'd4;
    @(posedge clk); #1;
    m.start = 1'b0; m.in_valid = 1'b1; m.in_data = 5;
    @(posedge clk); #1;
    m.in_data = -3; m.start = 1'b1; m.count = 16'd0;
    @(posedge clk); #1;
    m.start = 1'b0;
    tests_run++;
    if (m.busy !== 1'b1 || m.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_start got busy=%b done=%b want 1/0", m.busy, m.done);
    end
    @(posedge clk); #1;
    tests_run++;
    if (m.min_val !== -32'sd3 || m.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL pre_reset got min=%0d in_ready=%b want -3/0", m.min_val, m.in_ready);
    end
    rst = 1'b1;
    #1;
    $display("[TB] mid-scan reset: busy=%b ready=%b min=%0d max=%0d",
             m.busy, m.in_ready, m.min_val, m.max_val);
    tests_run++;
    if ({m.in_ready, m.busy, m.done} !== 3'b000 || m.min_val !== 32'sd0 || m.max_val !== 32'sd0) begin
      tests_failed++;
      $display("FAIL mid_reset got flags=%b min=%0d max=%0d want 000/0/0",
               {m.in_ready, m.busy, m.done}, m.min_val, m.max_val);
    end
    m.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    vec[0] = 3; vec[1] = 1;
    run_scan(2, -1, 0, d, r);
    $display("[TB] after reset: done@%0d min=%0d max=%0d", d, m.min_val, m.max_val);
    tests_run++;
    if (d !== 5 || m.min_val !== 32'sd1 || m.max_val !== 32'sd3) begin
      tests_failed++;
      $display("FAIL post_reset_scan got done@%0d min=%0d max=%0d want 5/1/3", d, m.min_val, m.max_val);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    tests_run = 0;
    tests_failed = 0;
    m.start = 1'b0;
    m.count = '0;
    m.in_data = '0;
    m.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) vec[i] = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_zero_count();
    test_stall();
    test_single();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
